// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: fetch-stage state encoding and shared constants
package ifu_fetch_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_FAULT} state_t;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/ifu_skid_buf.sv
// ifu_skid_buf: one-entry holding slot for a response that arrives while decode is stalled
module ifu_skid_buf
  import ifu_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic              pop,
  input  logic              clr,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [DATA_W-1:0] d_inst,
  input  logic              d_fault,
  output logic              buf_valid,
  output logic [ADDR_W-1:0] q_pc,
  output logic [DATA_W-1:0] q_inst,
  output logic              q_fault
);
  // occupancy plus captured entry; clear wins over push and pop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_valid <= 1'b0;
      q_pc      <= '0;
      q_inst    <= DATA_W'(NOP_INST);
      q_fault   <= 1'b0;
    end else begin
      buf_valid <= ~clr & (push | (buf_valid & ~pop));
      if (push) begin
        q_pc    <= d_pc;
        q_inst  <= d_inst;
        q_fault <= d_fault;
      end
    end
  end
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: pc owner issuing one outstanding fetch at a time and feeding decode
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ac2if_stall,
  input  logic              ac2if_flush,
  input  logic [ADDR_W-1:0] ac2if_flush_pc,
  output logic              ibus_req_valid,
  input  logic              ibus_req_ready,
  output logic [ADDR_W-1:0] ibus_req_addr,
  input  logic              ibus_rsp_valid,
  input  logic [DATA_W-1:0] ibus_rsp_data,
  input  logic              ibus_rsp_err,
  output logic              if2id_valid,
  output logic [ADDR_W-1:0] if2id_pc,
  output logic [DATA_W-1:0] if2id_inst,
  output logic              if2id_fault,
  output logic              if2ac_hazard
);
  localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_INST);
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx, b_pc;
  logic [DATA_W-1:0] b_inst, rsp_inst;
  logic buf_valid, b_fault, hs, rsp, load_out, push, pop;
  assign hs             = ibus_req_valid & ibus_req_ready;
  assign rsp            = (state == S_WAIT) & ibus_rsp_valid & ~ac2if_flush;
  assign load_out       = rsp & (~ac2if_stall | ~if2id_valid);
  assign push           = rsp & ~load_out;
  assign pop            = buf_valid & ~ac2if_stall & ~ac2if_flush;
  assign rsp_inst       = ibus_rsp_err ? NOP : ibus_rsp_data;
  assign ibus_req_valid = (state == S_REQ) & ~buf_valid;
  assign ibus_req_addr  = pc;
  assign if2ac_hazard   = ~if2id_valid & (state != S_IDLE);
  ifu_skid_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_skid (
    .clk(clk), .rstn(rstn), .push(push), .pop(pop), .clr(ac2if_flush),
    .d_pc(pc), .d_inst(rsp_inst), .d_fault(ibus_rsp_err),
    .buf_valid(buf_valid), .q_pc(b_pc), .q_inst(b_inst), .q_fault(b_fault)
  );
  // state and pc registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end
  // next state; a flush leaves DROP behind whenever a response is still owed
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    case (state)
      S_IDLE:  state_nx = S_REQ;
      S_REQ:   state_nx = hs ? S_WAIT : S_REQ;
      S_WAIT:  if (ibus_rsp_valid) begin
                 state_nx = ibus_rsp_err ? S_FAULT : S_REQ;
                 pc_nx    = pc + ADDR_W'(PC_STEP);
               end
      S_DROP:  state_nx = ibus_rsp_valid ? S_REQ : S_DROP;
      default: state_nx = state;
    endcase
    if (ac2if_flush) begin
      pc_nx    = ac2if_flush_pc;
      state_nx = ((((state == S_WAIT) || (state == S_DROP)) && !ibus_rsp_valid) || hs) ? S_DROP : S_REQ;
    end
  end
  // decode-facing registers: flush kills, response or buffer loads, unstalled output drains
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if2id_valid <= 1'b0;
      if2id_pc    <= '0;
      if2id_inst  <= NOP;
      if2id_fault <= 1'b0;
    end else if (ac2if_flush) begin
      if2id_valid <= 1'b0;
      if2id_inst  <= NOP;
      if2id_fault <= 1'b0;
    end else if (load_out) begin
      if2id_valid <= 1'b1;
      if2id_pc    <= pc;
      if2id_inst  <= rsp_inst;
      if2id_fault <= ibus_rsp_err;
    end else if (pop) begin
      if2id_valid <= 1'b1;
      if2id_pc    <= b_pc;
      if2id_inst  <= b_inst;
      if2id_fault <= b_fault;
    end else if (!ac2if_stall) begin
      if2id_valid <= 1'b0;
      if2id_inst  <= NOP;
      if2id_fault <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed timing checks plus randomized run against a pc-stream model
module tb_ifu_fetch;
  localparam logic [31:0] RPC = 32'h100;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rstn = 0, stall = 0, flush = 0, rdy = 1;
  logic rsp_v = 0, rsp_err = 0;
  logic [31:0] flush_pc = 0, rsp_data = 0;
  logic req_v, v, fault, haz;
  logic [31:0] req_addr, pc, inst;
  int n_assert = 0, n_fail = 0, lat = 0, cnt = 0, consumed = 0;
  bit pending = 0, mdl = 0, in_fault = 0;
  logic [31:0] paddr = 0, exp_fetch = RPC, exp_out = RPC, err_addr = 32'h1;

  always #5 clk = ~clk;

  ifu_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rstn(rstn), .ac2if_stall(stall), .ac2if_flush(flush), .ac2if_flush_pc(flush_pc),
    .ibus_req_valid(req_v), .ibus_req_ready(rdy), .ibus_req_addr(req_addr),
    .ibus_rsp_valid(rsp_v), .ibus_rsp_data(rsp_data), .ibus_rsp_err(rsp_err),
    .if2id_valid(v), .if2id_pc(pc), .if2id_inst(inst), .if2id_fault(fault), .if2ac_hazard(haz)
  );

  function automatic logic [31:0] memf(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic bit is_err(logic [31:0] a);
    return (a == err_addr) || (a >= 32'h1000 && a < 32'h2000 && a[6:2] == 5'd7);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit hs, rv;
    logic [31:0] a;
    rv = pending && cnt == 0;
    rsp_v = rv;
    rsp_data = rv ? memf(paddr) : '0;
    rsp_err = rv && is_err(paddr);
    #1;
    hs = req_v && rdy;
    a = req_addr;
    if (mdl) begin
      chk("hazard", haz, !v);
      if (!v) chk("nop_when_idle", inst, NOP);
      if (in_fault) chk("no_req_after_fault", req_v, 0);
      if (hs) begin
        chk("req_addr", a, exp_fetch);
        exp_fetch += 4;
      end
      if (v && !stall && !flush) begin
        chk("out_pc", pc, exp_out);
        chk("out_inst", inst, is_err(exp_out) ? NOP : memf(exp_out));
        chk("out_fault", fault, is_err(exp_out));
        if (is_err(exp_out)) in_fault = 1;
        exp_out += 4;
        consumed++;
      end
      if (flush) begin
        exp_fetch = flush_pc;
        exp_out = flush_pc;
        in_fault = 0;
      end
    end
    @(posedge clk);
    if (rv) pending = 0;
    else if (pending) cnt--;
    if (hs) begin
      pending = 1;
      paddr = a;
      cnt = lat;
    end
    #1;
  endtask

  task automatic flush_tick(logic [31:0] t);
    flush = 1;
    flush_pc = t;
    tick();
    flush = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", v, 0);
    chk("rst_pc", pc, 0);
    chk("rst_inst", inst, NOP);
    chk("rst_fault", fault, 0);
    chk("rst_hazard", haz, 0);
    chk("rst_req_v", req_v, 0);
    chk("rst_req_addr", req_addr, RPC);
    rstn = 1;
    chk("c0_req_v", req_v, 0);
    tick();
    mdl = 1;
    chk("c1_req_v", req_v, 1);
    chk("c1_addr", req_addr, 32'h100);
    tick();
    tick();
    chk("c3_valid", v, 1);
    chk("c3_pc", pc, 32'h100);
    chk("c3_next_addr", req_addr, 32'h104);
    tick();
    chk("c4_valid", v, 0);
    tick();
    chk("c5_pc", pc, 32'h104);
    chk("c5_valid", v, 1);
    tick();
    tick();
    chk("c7_pc", pc, 32'h108);
    // stall while the response for 0x10c lands in the skid buffer
    stall = 1;
    tick();
    tick();
    chk("stall_valid", v, 1);
    chk("stall_req_v", req_v, 0);
    repeat (4) begin
      tick();
      chk("stall_hold_pc", pc, 32'h108);
      chk("stall_no_req", req_v, 0);
    end
    stall = 0;
    tick();
    chk("unstall_pc", pc, 32'h10C);
    chk("unstall_valid", v, 1);
    chk("unstall_req_v", req_v, 1);
    chk("unstall_addr", req_addr, 32'h110);
    // flush during a 3-cycle wait: stale response must be dropped
    lat = 3;
    tick();
    tick();
    flush_tick(32'h2000);
    chk("drop_valid", v, 0);
    chk("drop_req_v", req_v, 0);
    chk("drop_addr", req_addr, 32'h2000);
    lat = 0;
    tick();
    tick();
    chk("redir_req_v", req_v, 1);
    chk("redir_addr", req_addr, 32'h2000);
    tick();
    tick();
    chk("redir_pc", pc, 32'h2000);
    chk("redir_inst", inst, memf(32'h2000));
    // flush coincident with a response and a stall
    stall = 1;
    tick();
    chk("held_pc", pc, 32'h2000);
    stall = 1;
    flush_tick(32'h3000);
    stall = 0;
    chk("coinc_valid", v, 0);
    chk("coinc_req_v", req_v, 1);
    chk("coinc_addr", req_addr, 32'h3000);
    tick();
    tick();
    chk("coinc_pc", pc, 32'h3000);
    // access fault on 0x3004 halts fetch until a flush
    err_addr = 32'h3004;
    tick();
    tick();
    chk("fault_valid", v, 1);
    chk("fault_pc", pc, 32'h3004);
    chk("fault_inst", inst, NOP);
    chk("fault_flag", fault, 1);
    chk("fault_req_v", req_v, 0);
    repeat (3) begin
      tick();
      chk("fault_quiet", req_v, 0);
    end
    flush_tick(32'h300);
    chk("resume_req_v", req_v, 1);
    chk("resume_addr", req_addr, 32'h300);
    tick();
    tick();
    chk("resume_pc", pc, 32'h300);
    // pc wrap from the top of the address space
    flush_tick(32'hFFFF_FFFC);
    chk("wrap_drop_req_v", req_v, 0);
    tick();
    chk("wrap_req_v", req_v, 1);
    chk("wrap_addr", req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    chk("wrap_out_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_next_addr", req_addr, 32'h0);
    // randomized traffic against the pc-stream model
    consumed = 0;
    flush_tick(32'h1000);
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(0, 3);
      rdy = $urandom_range(0, 3) != 0;
      stall = $urandom_range(0, 2) == 0;
      flush = in_fault || $urandom_range(0, 29) == 0;
      flush_pc = $urandom_range(0, 15) == 0 ? 32'hFFFF_FFF8 : 32'h1000 + ($urandom_range(0, 1023) << 2);
      tick();
    end
    flush = 0;
    stall = 0;
    rdy = 1;
    chk("progress", consumed > 100, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
